phase_decoder: RTL and testbench

PHASE_DECODER -- requirements
Module: phase_decoder

---
 rtl/phase_decoder.sv | 113 +++++++++++
 tb/tb_phase_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_decoder.sv
// phase_decoder: registered one-hot index decoder with
// direct, strobe, scan and hold modes.
module phase_decoder #(
  parameter int SEL_W = 3,
  parameter int OUTS  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [SEL_W-1:0] SEL,
  input  logic             LOAD,
  output logic [OUTS-1:0]  OUT,
  output logic [SEL_W-1:0] IDX,
  output logic             WRAP,
  output logic             ERR
);

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_STROBE = 2'b01,
    M_SCAN   = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  localparam logic [SEL_W:0]   OUTS_LIM = (SEL_W+1)'(OUTS);
  localparam logic [SEL_W-1:0] LAST     = SEL_W'(OUTS-1);

  logic [OUTS-1:0]  out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  mode_e            mode;
  logic             sel_ok;
  logic             at_last;
  logic [SEL_W-1:0] idx_step;

  function automatic logic [OUTS-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    onehot = OUTS'(1) << i;
  endfunction

  assign mode     = mode_e'(MODE);
  assign sel_ok   = {1'b0, SEL} < OUTS_LIM;
  // scan wraps at OUTS-1, not at the natural width limit
  assign at_last  = idx_q == LAST;
  assign idx_step = at_last ? '0 : idx_q + SEL_W'(1);

  always_comb begin
    idx_d  = idx_q;
    out_d  = '0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (EN) begin
      unique case (mode)
        M_DIRECT: begin
          if (sel_ok) begin
            idx_d = SEL;
            out_d = onehot(SEL);
          end else begin
            err_d = 1'b1;
          end
        end
        M_STROBE: begin
          if (LOAD) begin
            if (sel_ok) begin
              idx_d = SEL;
              out_d = onehot(SEL);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        M_SCAN: begin
          if (LOAD && sel_ok) begin
            idx_d = SEL;
            out_d = onehot(SEL);
          end else begin
            err_d  = LOAD;
            idx_d  = idx_step;
            wrap_d = at_last;
            out_d  = onehot(idx_step);
          end
        end
        M_HOLD: begin
          out_d = out_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign OUT  = out_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_phase_decoder.sv
// tb_phase_decoder: two decoders (OUTS=8 and OUTS=6) on
// shared inputs, checked against an arithmetic model.
module tb_phase_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] sel = 3'd0;
  logic       load = 1'b0;

  logic [7:0] out_a;
  logic [2:0] idx_a;
  logic       wrap_a, err_a;
  logic [5:0] out_b;
  logic [2:0] idx_b;
  logic       wrap_b, err_b;

  int checks = 0;
  int failures = 0;

  int outs_of [2] = '{8, 6};
  int m_idx [2] = '{0, 0};
  int m_out [2] = '{0, 0};
  int m_wrap [2] = '{0, 0};
  int m_err [2] = '{0, 0};

  localparam logic [1:0] DIR = 2'b00;
  localparam logic [1:0] STB = 2'b01;
  localparam logic [1:0] SCN = 2'b10;
  localparam logic [1:0] HLD = 2'b11;

  phase_decoder ua (
    .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode),
    .SEL(sel), .LOAD(load), .OUT(out_a), .IDX(idx_a),
    .WRAP(wrap_a), .ERR(err_a)
  );

  phase_decoder #(.SEL_W(3), .OUTS(6)) ub (
    .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode),
    .SEL(sel), .LOAD(load), .OUT(out_b), .IDX(idx_b),
    .WRAP(wrap_b), .ERR(err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: index arithmetic modulo OUTS, one-hot as 1<<idx.
  task automatic mstep(input int k);
    int o, nidx, nout, nw, ne;
    bit ok;
    o = outs_of[k];
    nidx = m_idx[k];
    nout = 0;
    nw = 0;
    ne = 0;
    ok = int'(sel) < o;
    if (en) begin
      case (mode)
        DIR: begin
          if (ok) begin nidx = int'(sel); nout = 1 << sel; end
          else ne = 1;
        end
        STB: begin
          if (load) begin
            if (ok) begin nidx = int'(sel); nout = 1 << sel; end
            else ne = 1;
          end
        end
        SCN: begin
          if (load && ok) begin
            nidx = int'(sel);
            nout = 1 << sel;
          end else begin
            ne = int'(load);
            nidx = (m_idx[k] + 1) % o;
            nw = (nidx == 0) ? 1 : 0;
            nout = 1 << nidx;
          end
        end
        default: nout = m_out[k];
      endcase
    end
    m_idx[k] = nidx;
    m_out[k] = nout;
    m_wrap[k] = nw;
    m_err[k] = ne;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_idx[k] = 0; m_out[k] = 0;
        m_wrap[k] = 0; m_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) mstep(k);
    end
  end

  always @(negedge clk) begin
    chk("a.out", 32'(out_a), m_out[0]);
    chk("a.idx", 32'(idx_a), m_idx[0]);
    chk("a.wrap", 32'(wrap_a), m_wrap[0]);
    chk("a.err", 32'(err_a), m_err[0]);
    chk("b.out", 32'(out_b), m_out[1]);
    chk("b.idx", 32'(idx_b), m_idx[1]);
    chk("b.wrap", 32'(wrap_b), m_wrap[1]);
    chk("b.err", 32'(err_b), m_err[1]);
    chk("a.onehot", 32'($countones(out_a) <= 1), 1);
    chk("b.onehot", 32'($countones(out_b) <= 1), 1);
  end

  task automatic cyc(
    input logic e, input logic [1:0] m,
    input logic [2:0] s, input logic l
  );
    en = e; mode = m; sel = s; load = l;
    @(posedge clk);
    #1;
  endtask

  int exp_b_idx [7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_b_wrp [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", 32'(out_a), 0);
    chk("rst.idx", 32'(idx_a), 0);
    chk("rst.wrap", 32'(wrap_b), 0);
    chk("rst.err", 32'(err_b), 0);
    rst_n = 1'b1;

    cyc(1, DIR, 5, 0);
    chk("dir.out", 32'(out_a), 32'h20);
    chk("dir.idx", 32'(idx_a), 5);
    cyc(0, DIR, 5, 0);
    chk("en0.out", 32'(out_a), 0);
    chk("en0.idx", 32'(idx_a), 5);
    cyc(1, DIR, 7, 0);
    chk("dir7.b.err", 32'(err_b), 1);
    chk("dir7.b.idx", 32'(idx_b), 5);
    chk("dir7.a.out", 32'(out_a), 32'h80);
    cyc(1, DIR, 1, 0);
    chk("errclr.b", 32'(err_b), 0);

    cyc(1, STB, 2, 1);
    chk("stb.out", 32'(out_a), 32'h04);
    chk("stb.idx", 32'(idx_a), 2);
    cyc(1, STB, 2, 0);
    chk("stb.off", 32'(out_a), 0);
    chk("stb.hold", 32'(idx_a), 2);
    cyc(1, STB, 1, 1);
    chk("b2b.1", 32'(out_a), 32'h02);
    cyc(1, STB, 3, 1);
    chk("b2b.2", 32'(out_a), 32'h08);
    cyc(1, STB, 6, 1);
    chk("stb6.b.err", 32'(err_b), 1);
    chk("stb6.b.idx", 32'(idx_b), 3);
    chk("stb6.a.out", 32'(out_a), 32'h40);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1, SCN, 0, 0);
      chk("scan.b.idx", 32'(idx_b), exp_b_idx[i]);
      chk("scan.b.wrap", 32'(wrap_b), exp_b_wrp[i]);
      chk("scan.a.idx", 32'(idx_a), i + 1);
    end
    cyc(1, SCN, 0, 0);
    chk("scan.a.wrap", 32'(wrap_a), 1);
    chk("scan.a.idx0", 32'(idx_a), 0);
    repeat (3) cyc(1, SCN, 0, 0);
    chk("scan.b.at5", 32'(idx_b), 5);

    cyc(1, SCN, 3, 1);
    chk("ld.b.idx", 32'(idx_b), 3);
    chk("ld.b.wrap", 32'(wrap_b), 0);
    cyc(1, SCN, 7, 1);
    chk("ldbad.b.err", 32'(err_b), 1);
    chk("ldbad.b.idx", 32'(idx_b), 4);
    chk("ldbad.a.idx", 32'(idx_a), 7);
    cyc(1, SCN, 0, 0);
    cyc(1, SCN, 6, 1);
    chk("ldwrap.b.err", 32'(err_b), 1);
    chk("ldwrap.b.wrap", 32'(wrap_b), 1);
    chk("ldwrap.b.idx", 32'(idx_b), 0);

    repeat (4) cyc(1, SCN, 0, 0);
    chk("pre_rst.b.idx", 32'(idx_b), 4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.b.out", 32'(out_b), 0);
    chk("arst.b.idx", 32'(idx_b), 0);
    #1 rst_n = 1'b1;
    cyc(1, SCN, 0, 0);
    chk("post_rst.b.idx", 32'(idx_b), 1);
    chk("post_rst.b.wrap", 32'(wrap_b), 0);

    repeat (2) cyc(1, SCN, 0, 0);
    cyc(1, HLD, 5, 1);
    chk("hold.b.idx", 32'(idx_b), 3);
    chk("hold.b.out", 32'(out_b), 32'h08);
    cyc(1, HLD, 0, 0);
    cyc(1, HLD, 7, 1);
    chk("hold3.b.idx", 32'(idx_b), 3);
    chk("hold3.b.out", 32'(out_b), 32'h08);
    chk("hold3.b.err", 32'(err_b), 0);
    cyc(1, SCN, 0, 0);
    chk("unhold.b.idx", 32'(idx_b), 4);
    chk("unhold.b.out", 32'(out_b), 32'h10);

    cyc(0, HLD, 0, 0);
    chk("en0hold.out", 32'(out_b), 0);
    cyc(1, HLD, 2, 1);
    chk("holdz.out", 32'(out_b), 0);
    chk("holdz.idx", 32'(idx_b), 4);
    cyc(1, STB, 0, 0);
    chk("mode.stb.idx", 32'(idx_b), 4);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
